// File: rtl/dec_i2c_rx.sv
// I2C target receiver: synchronises scl/sda, tracks START/STOP, matches the
// 7-bit address, ACKs write bytes up to MAX_BYTES and strobes each received byte.
module dec_i2c_rx #(
  parameter int SYNC_STAGES     = 2,
  parameter int MAX_BYTES       = 4,
  parameter int GENERAL_CALL_EN = 1,
  parameter int BCOUNT_W        = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                scl,
  input  logic                sda_in,
  output logic                sda_oe,
  input  logic [6:0]          endereco_local,
  output logic [6:0]          endereco_recebido,
  output logic                operacao,
  output logic                casou,
  output logic [7:0]          dado_rx,
  output logic                dado_valido,
  output logic [BCOUNT_W-1:0] byte_count,
  output logic                start_det,
  output logic                stop_det,
  output logic                ocupado
);

  typedef enum logic [2:0] {IDLE, ADDR, ADDR_ACK, DATA, DATA_ACK, IGNORE} state_t;

  localparam logic [BCOUNT_W-1:0] MAX_B  = BCOUNT_W'(MAX_BYTES);
  localparam logic [BCOUNT_W-1:0] BC_SAT = '1;

  logic [SYNC_STAGES-1:0] scl_sync_reg, sda_sync_reg;
  logic scl_d_reg, sda_d_reg;
  logic scl_s, sda_s, scl_rise, scl_fall, start_cond, stop_cond;

  state_t              state_reg, state_next;
  logic [2:0]          bit_reg, bit_next;
  logic [6:0]          shift_reg, shift_next;
  logic                ack_on_reg, ack_on_next;
  logic                sda_oe_reg, sda_oe_next;
  logic [6:0]          addr_reg, addr_next;
  logic                op_reg, op_next;
  logic                casou_reg, casou_next;
  logic [7:0]          dado_reg, dado_next;
  logic                valid_reg, valid_next;
  logic [BCOUNT_W-1:0] bcount_reg, bcount_next;
  logic                start_reg, start_next;
  logic                stop_reg, stop_next;
  logic                busy_reg, busy_next;
  logic [7:0]          byte_w;
  logic                addr_hit;

  // Synchronisers preset to 1 so an idle bus never looks like an edge after reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scl_sync_reg <= '1;
      sda_sync_reg <= '1;
      scl_d_reg    <= 1'b1;
      sda_d_reg    <= 1'b1;
    end else begin
      scl_sync_reg <= {scl_sync_reg[SYNC_STAGES-2:0], scl};
      sda_sync_reg <= {sda_sync_reg[SYNC_STAGES-2:0], sda_in};
      scl_d_reg    <= scl_sync_reg[SYNC_STAGES-1];
      sda_d_reg    <= sda_sync_reg[SYNC_STAGES-1];
    end
  end

  assign scl_s      = scl_sync_reg[SYNC_STAGES-1];
  assign sda_s      = sda_sync_reg[SYNC_STAGES-1];
  assign scl_rise   = scl_s & ~scl_d_reg;
  assign scl_fall   = ~scl_s & scl_d_reg;
  assign start_cond = scl_s & sda_d_reg & ~sda_s;
  assign stop_cond  = scl_s & ~sda_d_reg & sda_s;
  assign byte_w     = {shift_reg, sda_s};
  assign addr_hit   = (byte_w[7:1] == endereco_local) ||
                      ((GENERAL_CALL_EN != 0) && (byte_w[7:1] == 7'h00) && !byte_w[0]);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg  <= IDLE;
      bit_reg    <= '0;
      shift_reg  <= '0;
      ack_on_reg <= 1'b0;
      sda_oe_reg <= 1'b0;
      addr_reg   <= '0;
      op_reg     <= 1'b0;
      casou_reg  <= 1'b0;
      dado_reg   <= '0;
      valid_reg  <= 1'b0;
      bcount_reg <= '0;
      start_reg  <= 1'b0;
      stop_reg   <= 1'b0;
      busy_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      bit_reg    <= bit_next;
      shift_reg  <= shift_next;
      ack_on_reg <= ack_on_next;
      sda_oe_reg <= sda_oe_next;
      addr_reg   <= addr_next;
      op_reg     <= op_next;
      casou_reg  <= casou_next;
      dado_reg   <= dado_next;
      valid_reg  <= valid_next;
      bcount_reg <= bcount_next;
      start_reg  <= start_next;
      stop_reg   <= stop_next;
      busy_reg   <= busy_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    bit_next    = bit_reg;
    shift_next  = shift_reg;
    ack_on_next = ack_on_reg;
    sda_oe_next = sda_oe_reg;
    addr_next   = addr_reg;
    op_next     = op_reg;
    casou_next  = casou_reg;
    dado_next   = dado_reg;
    valid_next  = 1'b0;
    bcount_next = bcount_reg;
    start_next  = 1'b0;
    stop_next   = 1'b0;
    busy_next   = busy_reg;

    if (start_cond) begin
      start_next  = 1'b1;
      busy_next   = 1'b1;
      casou_next  = 1'b0;
      bcount_next = '0;
      bit_next    = '0;
      ack_on_next = 1'b0;
      sda_oe_next = 1'b0;
      state_next  = ADDR;
    end else if (stop_cond) begin
      stop_next   = 1'b1;
      busy_next   = 1'b0;
      casou_next  = 1'b0;
      bit_next    = '0;
      ack_on_next = 1'b0;
      sda_oe_next = 1'b0;
      state_next  = IDLE;
    end else begin
      case (state_reg)
        ADDR: if (scl_rise) begin
          shift_next = byte_w[6:0];
          bit_next   = bit_reg + 3'd1;
          if (bit_reg == 3'd7) begin
            addr_next   = byte_w[7:1];
            op_next     = byte_w[0];
            ack_on_next = 1'b0;
            if (addr_hit) begin
              casou_next = 1'b1;
              state_next = ADDR_ACK;
            end else begin
              state_next = IGNORE;
            end
          end
        end
        DATA: if (scl_rise) begin
          shift_next = byte_w[6:0];
          bit_next   = bit_reg + 3'd1;
          if (bit_reg == 3'd7) begin
            dado_next   = byte_w;
            valid_next  = 1'b1;
            ack_on_next = 1'b0;
            if (bcount_reg != BC_SAT) bcount_next = bcount_reg + BCOUNT_W'(1);
            state_next  = DATA_ACK;
          end
        end
        ADDR_ACK, DATA_ACK: begin
          // ACK slot spans from the fall that ends bit 8 to the fall that ends bit 9.
          if (state_reg == DATA_ACK && bcount_reg > MAX_B) begin
            sda_oe_next = 1'b0;
            state_next  = IGNORE;
          end else if (scl_fall) begin
            if (!ack_on_reg) begin
              sda_oe_next = 1'b1;
              ack_on_next = 1'b1;
            end else begin
              sda_oe_next = 1'b0;
              ack_on_next = 1'b0;
              bit_next    = '0;
              state_next  = (state_reg == ADDR_ACK && op_reg) ? IGNORE : DATA;
            end
          end
        end
        IGNORE: sda_oe_next = 1'b0;
        default: ;
      endcase
    end
  end

  assign sda_oe            = sda_oe_reg;
  assign endereco_recebido = addr_reg;
  assign operacao          = op_reg;
  assign casou             = casou_reg;
  assign dado_rx           = dado_reg;
  assign dado_valido       = valid_reg;
  assign byte_count        = bcount_reg;
  assign start_det         = start_reg;
  assign stop_det          = stop_reg;
  assign ocupado           = busy_reg;

endmodule

// File: tb/tb_dec_i2c_rx.sv
// Bench for dec_i2c_rx: two instances (MAX_BYTES=4/general call on, MAX_BYTES=2/off)
// share one bus; a vector table of whole transactions plus hand-written corner cases.
module tb_dec_i2c_rx;

  logic clk, reset, scl, sda_m;
  logic [6:0] loc;
  logic oe1, oe2, op1, op2, casou1, casou2, val1, val2, sd1, sd2, pd1, pd2, busy1, busy2;
  logic [6:0] ra1, ra2;
  logic [7:0] dado1, dado2;
  logic [2:0] bc1, bc2;
  logic sda_line;

  assign sda_line = sda_m & ~oe1 & ~oe2;

  dec_i2c_rx #(.SYNC_STAGES(2), .MAX_BYTES(4), .GENERAL_CALL_EN(1), .BCOUNT_W(3)) dut1 (
    .clk(clk), .reset(reset), .scl(scl), .sda_in(sda_line), .sda_oe(oe1),
    .endereco_local(loc), .endereco_recebido(ra1), .operacao(op1), .casou(casou1),
    .dado_rx(dado1), .dado_valido(val1), .byte_count(bc1), .start_det(sd1),
    .stop_det(pd1), .ocupado(busy1));

  dec_i2c_rx #(.SYNC_STAGES(2), .MAX_BYTES(2), .GENERAL_CALL_EN(0), .BCOUNT_W(3)) dut2 (
    .clk(clk), .reset(reset), .scl(scl), .sda_in(sda_line), .sda_oe(oe2),
    .endereco_local(loc), .endereco_recebido(ra2), .operacao(op2), .casou(casou2),
    .dado_rx(dado2), .dado_valido(val2), .byte_count(bc2), .start_det(sd2),
    .stop_det(pd2), .ocupado(busy2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nv1, nv2, ns1, np1;
  initial begin
    nv1 = 0; nv2 = 0; ns1 = 0; np1 = 0;
  end
  always @(negedge clk) begin
    if (val1) nv1 <= nv1 + 1;
    if (val2) nv2 <= nv2 + 1;
    if (sd1)  ns1 <= ns1 + 1;
    if (pd1)  np1 <= np1 + 1;
  end

  typedef struct {
    logic [6:0]  addr;
    logic        rw;
    int          nb;
    logic [23:0] data;
    logic [3:0]  ack1, ack2;
    logic        c1, c2;
    int          nv1, nv2;
    logic [2:0]  bc1, bc2;
    logic [7:0]  d1, d2;
  } vec_t;

  vec_t vt[6];
  int n_vec, n_err;
  logic stray;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Bus phases are built from 20/30 ns steps so every change lands on a clk negedge.
  task automatic bit_out(input logic b, output logic a1, output logic a2);
    #20 sda_m = b;
    #30 scl = 1'b1;
    #20 begin a1 = oe1; a2 = oe2; end
    #30 scl = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, output logic a1, output logic a2);
    logic s1, s2;
    for (int i = 7; i >= 0; i--) begin
      bit_out(b[i], s1, s2);
      if (s1 | s2) stray = 1'b1;
    end
    bit_out(1'b1, a1, a2);
  endtask

  task automatic do_start;
    sda_m = 1'b0;
    #50 scl = 1'b0;
  endtask

  task automatic do_rstart;
    #20 sda_m = 1'b1;
    #30 scl = 1'b1;
    #50 sda_m = 1'b0;
    #50 scl = 1'b0;
  endtask

  task automatic do_stop;
    #20 sda_m = 1'b0;
    #30 scl = 1'b1;
    #50 sda_m = 1'b1;
    #50;
  endtask

  task automatic run_vec(input int k, input vec_t v);
    int b1, b2, bs, bp;
    logic [3:0] m1, m2;
    logic a1, a2;
    b1 = nv1; b2 = nv2; bs = ns1; bp = np1;
    m1 = '0; m2 = '0; stray = 1'b0;
    do_start;
    send_byte({v.addr, v.rw}, a1, a2);
    m1[0] = a1; m2[0] = a2;
    check($sformatf("v%0d casou1", k), casou1, v.c1);
    check($sformatf("v%0d casou2", k), casou2, v.c2);
    check($sformatf("v%0d addr_rx", k), {ra1, op1}, {v.addr, v.rw});
    check($sformatf("v%0d addr_rx2", k), {ra2, op2}, {v.addr, v.rw});
    check($sformatf("v%0d ocupado_mid", k), busy1, 1);
    for (int i = 0; i < v.nb; i++) begin
      send_byte(v.data[23-8*i -: 8], a1, a2);
      m1[i+1] = a1; m2[i+1] = a2;
    end
    do_stop;
    check($sformatf("v%0d ack1", k), m1, v.ack1);
    check($sformatf("v%0d ack2", k), m2, v.ack2);
    check($sformatf("v%0d valid1", k), nv1 - b1, v.nv1);
    check($sformatf("v%0d valid2", k), nv2 - b2, v.nv2);
    check($sformatf("v%0d dado1", k), dado1, v.d1);
    check($sformatf("v%0d dado2", k), dado2, v.d2);
    check($sformatf("v%0d bc1", k), bc1, v.bc1);
    check($sformatf("v%0d bc2", k), bc2, v.bc2);
    check($sformatf("v%0d start_det", k), ns1 - bs, 1);
    check($sformatf("v%0d stop_det", k), np1 - bp, 1);
    check($sformatf("v%0d end_state", k), {busy1, casou1, oe1, busy2, casou2, oe2}, 0);
    check($sformatf("v%0d stray_oe", k), stray, 0);
    $display("vec %0d: addr=%02h rw=%0d bytes=%0d ack1=%b ack2=%b dado1=%02h bc1=%0d",
             k, v.addr, v.rw, v.nb, m1, m2, dado1, bc1);
  endtask

  initial begin
    int b1, bs, bp;
    logic a1, a2;
    n_vec = 0; n_err = 0; stray = 1'b0;
    loc = 7'h48; scl = 1'b1; sda_m = 1'b1; reset = 1'b0;

    //          addr  rw  nb  data       ack1     ack2     c1 c2 nv1 nv2 bc1 bc2 d1     d2
    vt[0] = '{7'h48, 1'b0, 1, 24'hA50000, 4'b0011, 4'b0011, 1, 1, 1, 1, 3'd1, 3'd1, 8'hA5, 8'hA5};
    vt[1] = '{7'h49, 1'b0, 1, 24'h5A0000, 4'b0000, 4'b0000, 0, 0, 0, 0, 3'd0, 3'd0, 8'hA5, 8'hA5};
    vt[2] = '{7'h48, 1'b0, 3, 24'h112233, 4'b1111, 4'b0111, 1, 1, 3, 3, 3'd3, 3'd3, 8'h33, 8'h33};
    vt[3] = '{7'h00, 1'b0, 1, 24'h7E0000, 4'b0011, 4'b0000, 1, 0, 1, 0, 3'd1, 3'd0, 8'h7E, 8'h33};
    vt[4] = '{7'h00, 1'b1, 0, 24'h000000, 4'b0000, 4'b0000, 0, 0, 0, 0, 3'd0, 3'd0, 8'h7E, 8'h33};
    vt[5] = '{7'h48, 1'b1, 0, 24'h000000, 4'b0001, 4'b0001, 1, 1, 0, 0, 3'd0, 3'd0, 8'h7E, 8'h33};

    repeat (3) @(negedge clk);
    check("reset_state", {oe1, ra1, op1, casou1, dado1, val1, bc1, sd1, pd1, busy1}, 0);
    $display("reset: outputs=%0h", {oe1, ra1, op1, casou1, dado1, val1, bc1, sd1, pd1, busy1});
    reset = 1'b1;
    repeat (3) @(negedge clk);

    for (int k = 0; k < 6; k++) run_vec(k, vt[k]);

    // Repeated START after one data byte, then a read address.
    b1 = nv1; bs = ns1; bp = np1;
    do_start;
    send_byte(8'h90, a1, a2);
    send_byte(8'h11, a1, a2);
    check("rs ack_byte", a1, 1);
    do_rstart;
    check("rs bc_cleared", {bc1, bc2}, 0);
    send_byte(8'h91, a1, a2);
    check("rs ack_read", {a1, a2}, 2'b11);
    check("rs operacao", {op1, op2}, 2'b11);
    do_stop;
    check("rs start_det", ns1 - bs, 2);
    check("rs valid", nv1 - b1, 1);
    check("rs dado", dado1, 8'h11);
    check("rs stop_det", np1 - bp, 1);
    $display("rstart: starts=%0d valids=%0d op=%0d dado=%02h", ns1 - bs, nv1 - b1, op1, dado1);

    // STOP after a partial byte.
    b1 = nv1; bp = np1;
    do_start;
    send_byte(8'h90, a1, a2);
    bit_out(1'b1, a1, a2); bit_out(1'b0, a1, a2);
    bit_out(1'b1, a1, a2); bit_out(1'b0, a1, a2);
    do_stop;
    check("ps valid", nv1 - b1, 0);
    check("ps stop_det", np1 - bp, 1);
    check("ps end_state", {busy1, casou1, oe1, bc1}, 0);
    $display("partial stop: valids=%0d stops=%0d busy=%0d", nv1 - b1, np1 - bp, busy1);

    // Asynchronous reset while the data ACK is being driven.
    do_start;
    send_byte(8'h90, a1, a2);
    for (int i = 7; i >= 0; i--) bit_out(i[0], a1, a2);
    #20 sda_m = 1'b1;
    #30 scl = 1'b1;
    #20 check("ar oe_before", oe1, 1);
    reset = 1'b0;
    #1 check("ar outputs1", {oe1, ra1, op1, casou1, dado1, val1, bc1, sd1, pd1, busy1}, 0);
    check("ar outputs2", {oe2, ra2, op2, casou2, dado2, val2, bc2, sd2, pd2, busy2}, 0);
    $display("async reset: outputs1=%0h", {oe1, ra1, op1, casou1, dado1, val1, bc1, busy1});
    #29 reset = 1'b1;
    #100;
    run_vec(6, vt[0]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dec_i2c_rx.md
Name: dec_i2c_rx

Overview:
Parametrised I2C target-side receiver, the successor to dec_i2c. It oversamples scl/sda on clk and detects START, repeated START and STOP. It matches the 7-bit address against endereco_local, drives ACK, and delivers a multi-byte write payload byte-by-byte with a valid strobe. Read transfers are acknowledged at address time only; no data is driven.

Parameters:
SYNC_STAGES, 2, flip-flop depth of the scl/sda input synchronisers (min 2)
MAX_BYTES, 4, data bytes ACKed per transaction; later bytes are NACKed
GENERAL_CALL_EN, 1, when 1 address 7'h00 also matches
BCOUNT_W, 3, width of byte_count (must hold MAX_BYTES)

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-low reset
scl  in  1  I2C clock pin (asynchronous to clk)
sda_in  in  1  I2C data pin, input side
sda_oe  out  1  1 = pull sda low (open-drain ACK drive)
endereco_local  in  7  own address, sampled at each address compare
endereco_recebido  out  7  last received address
operacao  out  1  R/W bit of last address byte (1 = read)
casou  out  1  address matched, held high until STOP or START
dado_rx  out  8  last received data byte, MSB first on the wire
dado_valido  out  1  one-cycle strobe, dado_rx updated
byte_count  out  BCOUNT_W  data bytes received this transaction (saturating)
start_det  out  1  one-cycle pulse on START or repeated START
stop_det  out  1  one-cycle pulse on STOP
ocupado  out  1  high from START to STOP

Behaviour:
- Reset (reset=0, async): all outputs 0, FSM in IDLE, synchronisers preset to 1 (idle bus).
- Synchronisation: scl_s/sda_s are the outputs of SYNC_STAGES flops. Edges are detected against one further registered copy. All detections lag the pin by SYNC_STAGES+1 clk.
- Timing: scl high and low phases must each be ≥ SYNC_STAGES+2 clk. sda must be stable across synced scl rise.
- START: sda_s falls while scl_s=1. Pulse start_det, ocupado=1, casou=0, byte_count=0, bit counter cleared, go to ADDR. This is valid from ANY state (repeated START).
- STOP: sda_s rises while scl_s=1. Pulse stop_det, ocupado=0, casou=0, sda_oe=0, go to IDLE. This is valid from any state, including mid-byte; a partial byte is discarded and dado_valido is not pulsed.
- START/STOP take priority over scl-edge actions in the same clk.
- States: IDLE, ADDR, ADDR_ACK, DATA, DATA_ACK, IGNORE.
- ADDR: shift sda_s on each synced scl rise. On the 8th bit, latch endereco_recebido = bits[7:1] and operacao = bit[0]. Match = (addr == endereco_local) or (GENERAL_CALL_EN and addr == 0 and operacao == 0).
  - match: casou=1, go to ADDR_ACK.
  - no match: go to IGNORE.
- ADDR_ACK: sda_oe=1 from the next synced scl fall until the following synced scl fall.
  - operacao=0: then go to DATA.
  - operacao=1: then go to IGNORE.
- DATA: shift 8 bits on synced scl rises. On the 8th rise, dado_rx = byte and pulse dado_valido in that same clk. byte_count increments, saturating at 2^BCOUNT_W-1. Go to DATA_ACK.
- DATA_ACK: if byte_count ≤ MAX_BYTES, drive sda_oe as in ADDR_ACK and return to DATA. Otherwise leave sda_oe=0 (NACK) and go to IGNORE. dado_valido still pulses for the NACKed byte.
- IGNORE: sda_oe=0. Wait for START or STOP.
- sda_oe is never 1 outside ADDR_ACK/DATA_ACK.
- Own ACK drive does not trigger START/STOP, because sda only changes while scl is low.

Test Plan:
- Write 0x48+W, byte 0xA5, STOP; endereco_local=7'h48, clk 10 ns, scl 100 ns -> ACK low during 9th clock after address and after data; dado_rx=8'hA5 with a one-clk dado_valido; byte_count=1; stop_det pulse; ocupado=0.
- Address 7'h49 with endereco_local=7'h48 -> sda_oe never 1, casou=0, no dado_valido; endereco_recebido=7'h49.
- MAX_BYTES=2, write bytes 0x11, 0x22, 0x33 -> first two ACKed; third gets dado_valido with dado_rx=8'h33 but no ACK; byte_count=3.
- Repeated START after byte 0x11, then 0x48+R -> start_det pulses twice, byte_count reset to 0, operacao=1, ACK on address, no further valid.
- STOP after 4 data bits -> no dado_valido, FSM IDLE, stop_det pulse. General call 7'h00+W with GENERAL_CALL_EN=1 -> ACK; with GENERAL_CALL_EN=0 -> NACK.
- reset=0 asserted mid-DATA while sda_oe=1 -> all outputs 0 immediately (async). After release, a new START transaction completes normally.
